// File: rtl/z80fi_tracer_if.sv
// Z80FI tracer bus: core-side observation inputs and trace record outputs.
// z80fi_error is present only when Z80FI_TRACER_ERR_EN is defined.
interface z80fi_tracer_if;
  logic        insn_start;
  logic        insn_byte_valid;
  logic [7:0]  insn_byte;
  logic        insn_done;
  logic [7:0]  core_reg_a;
  logic [7:0]  core_reg_b;
  logic [7:0]  core_reg_c;
  logic [7:0]  core_reg_d;
  logic [7:0]  core_reg_e;
  logic [7:0]  core_reg_h;
  logic [7:0]  core_reg_l;
  logic [15:0] core_reg_ip;

  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [7:0]  z80fi_reg_a_in;
  logic [7:0]  z80fi_reg_b_in;
  logic [7:0]  z80fi_reg_c_in;
  logic [7:0]  z80fi_reg_d_in;
  logic [7:0]  z80fi_reg_e_in;
  logic [7:0]  z80fi_reg_h_in;
  logic [7:0]  z80fi_reg_l_in;
  logic [15:0] z80fi_reg_ip_in;
  logic [7:0]  z80fi_reg_a_out;
  logic [7:0]  z80fi_reg_b_out;
  logic [7:0]  z80fi_reg_c_out;
  logic [7:0]  z80fi_reg_d_out;
  logic [7:0]  z80fi_reg_e_out;
  logic [7:0]  z80fi_reg_h_out;
  logic [7:0]  z80fi_reg_l_out;
  logic [15:0] z80fi_reg_ip_out;
`ifdef Z80FI_TRACER_ERR_EN
  logic        z80fi_error;
`endif

  modport master (
    output insn_start, insn_byte_valid, insn_byte, insn_done,
    output core_reg_a, core_reg_b, core_reg_c, core_reg_d,
    output core_reg_e, core_reg_h, core_reg_l, core_reg_ip,
`ifdef Z80FI_TRACER_ERR_EN
    input  z80fi_error,
`endif
    input  z80fi_valid, z80fi_insn, z80fi_insn_len,
    input  z80fi_reg_a_in, z80fi_reg_b_in, z80fi_reg_c_in,
    input  z80fi_reg_d_in, z80fi_reg_e_in, z80fi_reg_h_in,
    input  z80fi_reg_l_in, z80fi_reg_ip_in,
    input  z80fi_reg_a_out, z80fi_reg_b_out, z80fi_reg_c_out,
    input  z80fi_reg_d_out, z80fi_reg_e_out, z80fi_reg_h_out,
    input  z80fi_reg_l_out, z80fi_reg_ip_out
  );

  modport slave (
    input  insn_start, insn_byte_valid, insn_byte, insn_done,
    input  core_reg_a, core_reg_b, core_reg_c, core_reg_d,
    input  core_reg_e, core_reg_h, core_reg_l, core_reg_ip,
`ifdef Z80FI_TRACER_ERR_EN
    output z80fi_error,
`endif
    output z80fi_valid, z80fi_insn, z80fi_insn_len,
    output z80fi_reg_a_in, z80fi_reg_b_in, z80fi_reg_c_in,
    output z80fi_reg_d_in, z80fi_reg_e_in, z80fi_reg_h_in,
    output z80fi_reg_l_in, z80fi_reg_ip_in,
    output z80fi_reg_a_out, z80fi_reg_b_out, z80fi_reg_c_out,
    output z80fi_reg_d_out, z80fi_reg_e_out, z80fi_reg_h_out,
    output z80fi_reg_l_out, z80fi_reg_ip_out
  );
endinterface

// File: rtl/z80fi_tracer.sv
// Z80FI instruction tracer: collects bytes and register snapshots per insn.
// Optional sticky protocol-error flag under Z80FI_TRACER_ERR_EN.
module z80fi_tracer (
  input logic           clk,
  input logic           reset,
  z80fi_tracer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t      r_state;
  logic        r_chain;
  logic [31:0] r_buf;
  logic [2:0]  r_len;
  logic [71:0] r_in_sh;
  logic        r_valid;
  logic [31:0] r_insn;
  logic [2:0]  r_rlen;
  logic [71:0] r_rin;
  logic [71:0] r_rout;

  logic [71:0] w_core;
  logic        w_open;
  logic        w_take;
  logic        w_full;
  logic        w_emit;
  logic [31:0] w_buf_n;
  logic [2:0]  w_len_n;

  assign w_core = {bus.core_reg_a, bus.core_reg_b, bus.core_reg_c,
                   bus.core_reg_d, bus.core_reg_e, bus.core_reg_h,
                   bus.core_reg_l, bus.core_reg_ip};

  // EMIT of a chained record still has the next record open
  assign w_open = (r_state == COLLECT) ||
                  ((r_state == EMIT) && r_chain);
  assign w_take = w_open && bus.insn_byte_valid && !bus.insn_start;
  assign w_full = r_len[2];
  assign w_emit = w_open && bus.insn_done;

  always_comb begin
    w_buf_n = r_buf;
    w_len_n = r_len;
    if (w_take && !w_full) begin
      w_buf_n[8*r_len[1:0] +: 8] = bus.insn_byte;
      w_len_n = r_len + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_chain <= 1'b0;
      r_buf   <= '0;
      r_len   <= '0;
      r_in_sh <= '0;
      r_valid <= 1'b0;
      r_insn  <= '0;
      r_rlen  <= '0;
      r_rin   <= '0;
      r_rout  <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_insn  <= w_buf_n;
        r_rlen  <= w_len_n;
        r_rin   <= r_in_sh;
        r_rout  <= w_core;
        r_chain <= bus.insn_start;
      end
      // a byte in the start cycle belongs to the new record
      if (bus.insn_start) begin
        r_in_sh <= w_core;
        r_buf   <= bus.insn_byte_valid ? {24'h0, bus.insn_byte} : 32'h0;
        r_len   <= bus.insn_byte_valid ? 3'd1 : 3'd0;
      end else begin
        r_buf   <= w_buf_n;
        r_len   <= w_len_n;
      end
      if (w_emit)
        r_state <= EMIT;
      else if (bus.insn_start)
        r_state <= COLLECT;
      else if (r_state == EMIT)
        r_state <= r_chain ? COLLECT : IDLE;
    end
  end

`ifdef Z80FI_TRACER_ERR_EN
  logic r_err;
  logic w_err;

  assign w_err = (w_take && w_full) ||
                 (bus.insn_start && w_open && !bus.insn_done) ||
                 (bus.insn_done && !w_open) ||
                 (w_emit && (w_len_n == 3'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_err)
      r_err <= 1'b1;
  end

  assign bus.z80fi_error = r_err;
`endif

  assign bus.z80fi_valid      = r_valid;
  assign bus.z80fi_insn       = r_insn;
  assign bus.z80fi_insn_len   = r_rlen;
  assign bus.z80fi_reg_a_in   = r_rin[71:64];
  assign bus.z80fi_reg_b_in   = r_rin[63:56];
  assign bus.z80fi_reg_c_in   = r_rin[55:48];
  assign bus.z80fi_reg_d_in   = r_rin[47:40];
  assign bus.z80fi_reg_e_in   = r_rin[39:32];
  assign bus.z80fi_reg_h_in   = r_rin[31:24];
  assign bus.z80fi_reg_l_in   = r_rin[23:16];
  assign bus.z80fi_reg_ip_in  = r_rin[15:0];
  assign bus.z80fi_reg_a_out  = r_rout[71:64];
  assign bus.z80fi_reg_b_out  = r_rout[63:56];
  assign bus.z80fi_reg_c_out  = r_rout[55:48];
  assign bus.z80fi_reg_d_out  = r_rout[47:40];
  assign bus.z80fi_reg_e_out  = r_rout[39:32];
  assign bus.z80fi_reg_h_out  = r_rout[31:24];
  assign bus.z80fi_reg_l_out  = r_rout[23:16];
  assign bus.z80fi_reg_ip_out = r_rout[15:0];
endmodule

// File: tb/tb_z80fi_tracer.sv
// Directed self-checking bench for z80fi_tracer.
// Error-flag checks are compiled only with Z80FI_TRACER_ERR_EN.
module tb_z80fi_tracer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  z80fi_tracer_if bus ();

  z80fi_tracer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.insn_start      = 1'b0;
    bus.insn_byte_valid = 1'b0;
    bus.insn_byte       = 8'h00;
    bus.insn_done       = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.z80fi_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %0h want 0", bus.z80fi_valid);
    end
    checks++;
    if (bus.z80fi_insn !== 32'h0 || bus.z80fi_insn_len !== 3'd0) begin
      errors++;
      $display("FAIL rst_insn got %0h/%0d want 0/0",
               bus.z80fi_insn, bus.z80fi_insn_len);
    end
    checks++;
    if (bus.z80fi_reg_a_in !== 8'h0 || bus.z80fi_reg_ip_out !== 16'h0) begin
      errors++;
      $display("FAIL rst_regs got %0h/%0h want 0/0",
               bus.z80fi_reg_a_in, bus.z80fi_reg_ip_out);
    end
`ifdef Z80FI_TRACER_ERR_EN
    checks++;
    if (bus.z80fi_error !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %0h want 0", bus.z80fi_error);
    end
`endif
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bus.core_reg_a      = 8'h12;
    bus.core_reg_ip     = 16'h0100;
    bus.insn_start      = 1'b1;
    bus.insn_byte_valid = 1'b1;
    bus.insn_byte       = 8'h78;
    tick();
    idle_in();
    bus.core_reg_a  = 8'h34;
    bus.core_reg_ip = 16'h0101;
    bus.insn_done   = 1'b1;
    checks++;
    if (bus.z80fi_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got %0h want 0", bus.z80fi_valid);
    end
    tick();
    bus.insn_done = 1'b0;
    checks++;
    if (bus.z80fi_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_valid got %0h want 1", bus.z80fi_valid);
    end
    checks++;
    if (bus.z80fi_insn !== 32'h00000078 || bus.z80fi_insn_len !== 3'd1) begin
      errors++;
      $display("FAIL basic_insn got %0h/%0d want 78/1",
               bus.z80fi_insn, bus.z80fi_insn_len);
    end
    checks++;
    if (bus.z80fi_reg_a_in !== 8'h12 || bus.z80fi_reg_a_out !== 8'h34) begin
      errors++;
      $display("FAIL basic_a got %0h/%0h want 12/34",
               bus.z80fi_reg_a_in, bus.z80fi_reg_a_out);
    end
    checks++;
    if (bus.z80fi_reg_ip_in !== 16'h0100 ||
        bus.z80fi_reg_ip_out !== 16'h0101) begin
      errors++;
      $display("FAIL basic_ip got %0h/%0h want 0100/0101",
               bus.z80fi_reg_ip_in, bus.z80fi_reg_ip_out);
    end
`ifdef Z80FI_TRACER_ERR_EN
    checks++;
    if (bus.z80fi_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got %0h want 0", bus.z80fi_error);
    end
`endif
    tick();
    checks++;
    if (bus.z80fi_valid !== 1'b0 || bus.z80fi_insn !== 32'h00000078) begin
      errors++;
      $display("FAIL basic_hold got %0h/%0h want 0/78",
               bus.z80fi_valid, bus.z80fi_insn);
    end
  endtask

  task automatic test_four_bytes();
    logic [7:0] seq [5];
    seq = '{8'hDD, 8'h21, 8'h34, 8'h12, 8'hFF};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.insn_start      = (i == 0);
      bus.insn_byte_valid = 1'b1;
      bus.insn_byte       = seq[i];
      tick();
    end
    idle_in();
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    checks++;
    if (bus.z80fi_valid !== 1'b1 || bus.z80fi_insn !== 32'h123421DD) begin
      errors++;
      $display("FAIL four_insn got %0h/%0h want 1/123421dd",
               bus.z80fi_valid, bus.z80fi_insn);
    end
    checks++;
    if (bus.z80fi_insn_len !== 3'd4) begin
      errors++;
      $display("FAIL four_len got %0d want 4", bus.z80fi_insn_len);
    end
`ifdef Z80FI_TRACER_ERR_EN
    checks++;
    if (bus.z80fi_error !== 1'b1) begin
      errors++;
      $display("FAIL four_err got %0h want 1", bus.z80fi_error);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.core_reg_b      = 8'h11;
    bus.insn_start      = 1'b1;
    bus.insn_byte_valid = 1'b1;
    bus.insn_byte       = 8'h00;
    tick();
    idle_in();
    bus.core_reg_b = 8'h55;
    bus.insn_start = 1'b1;
    bus.insn_done  = 1'b1;
    tick();
    idle_in();
    checks++;
    if (bus.z80fi_valid !== 1'b1 || bus.z80fi_reg_b_out !== 8'h55 ||
        bus.z80fi_reg_b_in !== 8'h11) begin
      errors++;
      $display("FAIL b2b_rec1 got %0h/%0h/%0h want 1/55/11",
               bus.z80fi_valid, bus.z80fi_reg_b_out, bus.z80fi_reg_b_in);
    end
    bus.insn_byte_valid = 1'b1;
    bus.insn_byte       = 8'h3E;
    tick();
    idle_in();
    checks++;
    if (bus.z80fi_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got %0h want 0", bus.z80fi_valid);
    end
    bus.core_reg_b = 8'h66;
    bus.insn_done  = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    checks++;
    if (bus.z80fi_valid !== 1'b1 || bus.z80fi_reg_b_in !== 8'h55 ||
        bus.z80fi_reg_b_out !== 8'h66) begin
      errors++;
      $display("FAIL b2b_rec2 got %0h/%0h/%0h want 1/55/66",
               bus.z80fi_valid, bus.z80fi_reg_b_in, bus.z80fi_reg_b_out);
    end
    checks++;
    if (bus.z80fi_insn !== 32'h3E || bus.z80fi_insn_len !== 3'd1) begin
      errors++;
      $display("FAIL b2b_insn got %0h/%0d want 3e/1",
               bus.z80fi_insn, bus.z80fi_insn_len);
    end
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    bus.insn_start      = 1'b1;
    bus.insn_byte_valid = 1'b1;
    bus.insn_byte       = 8'hAA;
    tick();
    bus.insn_byte = 8'hBB;
    tick();
    idle_in();
    checks++;
    if (bus.z80fi_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_novalid got %0h want 0", bus.z80fi_valid);
    end
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    checks++;
    if (bus.z80fi_valid !== 1'b1 || bus.z80fi_insn !== 32'hBB ||
        bus.z80fi_insn_len !== 3'd1) begin
      errors++;
      $display("FAIL abort_rec got %0h/%0h/%0d want 1/bb/1",
               bus.z80fi_valid, bus.z80fi_insn, bus.z80fi_insn_len);
    end
`ifdef Z80FI_TRACER_ERR_EN
    checks++;
    if (bus.z80fi_error !== 1'b1) begin
      errors++;
      $display("FAIL abort_err got %0h want 1", bus.z80fi_error);
    end
`endif
    tick();
  endtask

  task automatic test_zero_len();
    bus.insn_start = 1'b1;
    tick();
    idle_in();
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    checks++;
    if (bus.z80fi_valid !== 1'b1 || bus.z80fi_insn_len !== 3'd0 ||
        bus.z80fi_insn !== 32'h0) begin
      errors++;
      $display("FAIL zero_rec got %0h/%0d/%0h want 1/0/0",
               bus.z80fi_valid, bus.z80fi_insn_len, bus.z80fi_insn);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.core_reg_a      = 8'h77;
    bus.insn_start      = 1'b1;
    bus.insn_byte_valid = 1'b1;
    bus.insn_byte       = 8'h11;
    tick();
    bus.insn_start = 1'b0;
    bus.insn_byte  = 8'h22;
    tick();
    idle_in();
    bus.insn_done = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.z80fi_valid !== 1'b0 || bus.z80fi_insn !== 32'h0 ||
        bus.z80fi_insn_len !== 3'd0 || bus.z80fi_reg_a_out !== 8'h0) begin
      errors++;
      $display("FAIL rmid_zero got %0h/%0h/%0d/%0h want 0/0/0/0",
               bus.z80fi_valid, bus.z80fi_insn,
               bus.z80fi_insn_len, bus.z80fi_reg_a_out);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.z80fi_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_novalid got %0h want 0", bus.z80fi_valid);
    end
    do_reset();
    bus.insn_start      = 1'b1;
    bus.insn_byte_valid = 1'b1;
    bus.insn_byte       = 8'h44;
    tick();
    idle_in();
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    checks++;
    if (bus.z80fi_valid !== 1'b1 || bus.z80fi_insn !== 32'h44) begin
      errors++;
      $display("FAIL first_start got %0h/%0h want 1/44",
               bus.z80fi_valid, bus.z80fi_insn);
    end
    tick();
  endtask

  task automatic test_idle_done();
`ifdef Z80FI_TRACER_ERR_EN
    checks++;
    if (bus.z80fi_error !== 1'b0) begin
      errors++;
      $display("FAIL idone_pre_err got %0h want 0", bus.z80fi_error);
    end
`endif
    bus.insn_done = 1'b1;
    tick();
    bus.insn_done = 1'b0;
    tick();
    checks++;
    if (bus.z80fi_valid !== 1'b0 || bus.z80fi_insn !== 32'h44 ||
        bus.z80fi_insn_len !== 3'd1) begin
      errors++;
      $display("FAIL idone_hold got %0h/%0h/%0d want 0/44/1",
               bus.z80fi_valid, bus.z80fi_insn, bus.z80fi_insn_len);
    end
`ifdef Z80FI_TRACER_ERR_EN
    checks++;
    if (bus.z80fi_error !== 1'b1) begin
      errors++;
      $display("FAIL idone_err got %0h want 1", bus.z80fi_error);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_in();
    bus.core_reg_a  = 8'h00;
    bus.core_reg_b  = 8'h00;
    bus.core_reg_c  = 8'h00;
    bus.core_reg_d  = 8'h00;
    bus.core_reg_e  = 8'h00;
    bus.core_reg_h  = 8'h00;
    bus.core_reg_l  = 8'h00;
    bus.core_reg_ip = 16'h0000;
    test_reset();
    test_basic();
    test_four_bytes();
    test_back_to_back();
    test_abort();
    test_zero_len();
    test_reset_mid();
    test_idle_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
